// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: queue entry layout, FSM states, PC step.
package branch_pkg;

  localparam int PC_BITS = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic               predTaken;
    logic [PC_BITS-1:0] predTarget;
  } pred_entry_t;

  typedef enum logic {
    NORMAL,
    RECOVER
  } resolver_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch push, branch-unit resolve and BTB update signals of the branch resolver.
interface branch_resolver_if #(
  parameter int WIDTH   = 31,
  parameter int B_WIDTH = 7,
  parameter int DEPTH   = 8
);

  logic                     fetchValid;
  logic [WIDTH:0]           fetchPC;
  logic                     predTaken;
  logic [WIDTH:0]           predTarget;
  logic                     fetchReady;
  logic                     resValid;
  logic                     resTaken;
  logic [WIDTH:0]           resTarget;
  logic                     resReady;
  logic                     branch;
  logic                     wasTakenBranch;
  logic [B_WIDTH:0]         oldPC;
  logic [WIDTH:0]           resolvedTarget;
  logic                     mispredict;
  logic [WIDTH:0]           redirectPC;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output fetchValid, fetchPC, predTaken, predTarget,
    output resValid, resTaken, resTarget,
    input  fetchReady, resReady, branch, wasTakenBranch, oldPC,
    input  resolvedTarget, mispredict, redirectPC, count
  );

  modport slave (
    input  fetchValid, fetchPC, predTaken, predTarget,
    input  resValid, resTaken, resTarget,
    output fetchReady, resReady, branch, wasTakenBranch, oldPC,
    output resolvedTarget, mispredict, redirectPC, count
  );

endinterface

// File: rtl/pred_fifo.sv
// In-order circular buffer of predicted branches with single-cycle flush.
module pred_fifo
  import branch_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = pred_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 pushData,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 headData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW:0]      cnt;
  logic             doPush;
  logic             doPop;

  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign headData = mem[rdPtr];
  assign doPush   = push && !full && !flush;
  assign doPop    = pop && !empty && !flush;

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Compares queued predictions against resolved outcomes, drives BTB updates
// and redirects fetch on misprediction.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int WIDTH   = 31,
  parameter int B_WIDTH = 7,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolver_if.slave bus
);

  typedef struct packed {
    logic [WIDTH:0] pc;
    logic           predTaken;
    logic [WIDTH:0] predTarget;
  } entry_t;

  resolver_state_e        state;
  resolver_state_e        stateNext;
  entry_t                 pushEntry;
  entry_t                 head;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] fifoCount;
  logic                   fetchReady;
  logic                   resReady;
  logic                   push;
  logic                   resolve;
  logic                   miss;
  logic                   flush;
  logic [WIDTH:0]         nextPC;

  logic                   branchQ;
  logic                   takenQ;
  logic [B_WIDTH:0]       oldPCQ;
  logic [WIDTH:0]         targetQ;
  logic                   mispredictQ;
  logic [WIDTH:0]         redirectQ;

  assign fetchReady = !full && (state == NORMAL);
  assign resReady   = !empty;
  assign push       = bus.fetchValid && fetchReady;
  assign resolve    = bus.resValid && resReady;

  assign miss   = (head.predTaken != bus.resTaken) ||
                  (bus.resTaken && (head.predTarget != bus.resTarget));
  assign flush  = resolve && miss;
  assign nextPC = bus.resTaken ? bus.resTarget : head.pc + (WIDTH+1)'(PC_STEP);

  assign pushEntry = '{pc: bus.fetchPC, predTaken: bus.predTaken, predTarget: bus.predTarget};

  // A push racing a mispredicted resolve is on the wrong path, so flush wins.
  pred_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push && !flush),
    .pushData (pushEntry),
    .pop      (resolve && !miss),
    .flush    (flush),
    .headData (head),
    .full     (full),
    .empty    (empty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NORMAL;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      NORMAL:  if (flush) stateNext = RECOVER;
      RECOVER: stateNext = NORMAL;
      default: stateNext = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchQ     <= 1'b0;
      takenQ      <= 1'b0;
      oldPCQ      <= '0;
      targetQ     <= '0;
      mispredictQ <= 1'b0;
      redirectQ   <= '0;
    end else begin
      branchQ     <= resolve;
      takenQ      <= resolve && bus.resTaken;
      mispredictQ <= flush;
      if (resolve) begin
        oldPCQ    <= head.pc[B_WIDTH:0];
        targetQ   <= bus.resTarget;
        redirectQ <= nextPC;
      end
    end
  end

  assign bus.fetchReady     = fetchReady;
  assign bus.resReady       = resReady;
  assign bus.branch         = branchQ;
  assign bus.wasTakenBranch = takenQ;
  assign bus.oldPC          = oldPCQ;
  assign bus.resolvedTarget = targetQ;
  assign bus.mispredict     = mispredictQ;
  assign bus.redirectPC     = redirectQ;
  assign bus.count          = fifoCount;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: cycle table plus full/wrap and async reset sequences.
module tb_branch_resolver;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  branch_resolver_if #(.WIDTH(31), .B_WIDTH(7), .DEPTH(8)) bif ();

  branch_resolver #(.WIDTH(31), .B_WIDTH(7), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        pt;
    logic [31:0] ptgt;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        eBranch;
    logic        eTaken;
    logic [7:0]  eOld;
    logic [31:0] eTgt;
    logic        eMiss;
    logic [31:0] eRedir;
    logic [3:0]  eCount;
    logic        eFr;
    logic        eRr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fv, input logic [31:0] fpc, input logic pt, input logic [31:0] ptgt,
                     input logic rv, input logic rt, input logic [31:0] rtgt,
                     input logic eB, input logic eT, input logic [7:0] eO, input logic [31:0] eTg,
                     input logic eM, input logic [31:0] eRd, input logic [3:0] eC,
                     input logic eFr, input logic eRr);
    vec_t v;
    v = '{fv, fpc, pt, ptgt, rv, rt, rtgt, eB, eT, eO, eTg, eM, eRd, eC, eFr, eRr};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic pt, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
    bif.fetchValid = fv;
    bif.fetchPC    = fpc;
    bif.predTaken  = pt;
    bif.predTarget = ptgt;
    bif.resValid   = rv;
    bif.resTaken   = rt;
    bif.resTarget  = rtgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] qPC[$];
  logic        qT[$];
  logic [31:0] qTgt[$];

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // cycle-by-cycle vectors: inputs for one cycle, expected outputs after its edge
    add(0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   0, 1, 0);
    add(1, 32'h104,      1, 32'h200, 0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   1, 1, 1);
    add(0, 32'h0,        0, 32'h0,   1, 1, 32'h200, 1, 1, 8'h04, 32'h200, 0, 32'h0,   0, 1, 0);
    add(0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   0, 1, 0);
    add(1, 32'h1F0,      0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   1, 1, 1);
    add(0, 32'h0,        0, 32'h0,   1, 1, 32'h80,  1, 1, 8'hF0, 32'h80,  1, 32'h80,  0, 0, 0);
    add(0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   0, 1, 0);
    add(1, 32'h300,      1, 32'h400, 0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   1, 1, 1);
    add(1, 32'h310,      0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   2, 1, 1);
    add(1, 32'h320,      1, 32'h500, 0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   3, 1, 1);
    add(1, 32'h330,      0, 32'h0,   1, 0, 32'h0,   1, 0, 8'h00, 32'h0,   1, 32'h304, 0, 0, 0);
    add(1, 32'h340,      0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   0, 1, 0);
    add(0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   0, 1, 0);
    add(1, 32'h400,      0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   1, 1, 1);
    add(1, 32'h408,      1, 32'h800, 0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   2, 1, 1);
    add(0, 32'h0,        0, 32'h0,   1, 0, 32'h0,   1, 0, 8'h00, 32'h0,   0, 32'h0,   1, 1, 1);
    add(0, 32'h0,        0, 32'h0,   1, 1, 32'h800, 1, 1, 8'h08, 32'h800, 0, 32'h0,   0, 1, 0);
    add(1, 32'h5FC,      1, 32'h600, 0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   1, 1, 1);
    add(0, 32'h0,        0, 32'h0,   1, 1, 32'h700, 1, 1, 8'hFC, 32'h700, 1, 32'h700, 0, 0, 0);
    add(0, 32'h0,        0, 32'h0,   0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   0, 1, 0);
    add(1, 32'hFFFF_FFFC,1, 32'h10,  0, 0, 32'h0,   0, 0, 8'h00, 32'h0,   0, 32'h0,   1, 1, 1);
    add(0, 32'h0,        0, 32'h0,   1, 0, 32'h0,   1, 0, 8'hFC, 32'h0,   1, 32'h0,   0, 0, 0);
    add(0, 32'h0,        0, 32'h0,   1, 1, 32'h44,  0, 0, 8'h00, 32'h0,   0, 32'h0,   0, 1, 0);

    #2;
    chk("rst_branch", {31'b0, bif.branch}, 32'h0);
    chk("rst_taken", {31'b0, bif.wasTakenBranch}, 32'h0);
    chk("rst_mispredict", {31'b0, bif.mispredict}, 32'h0);
    chk("rst_oldPC", {24'b0, bif.oldPC}, 32'h0);
    chk("rst_resolvedTarget", bif.resolvedTarget, 32'h0);
    chk("rst_redirectPC", bif.redirectPC, 32'h0);
    chk("rst_count", {28'b0, bif.count}, 32'h0);
    chk("rst_fetchReady", {31'b0, bif.fetchReady}, 32'h1);
    chk("rst_resReady", {31'b0, bif.resReady}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].pt, vecs[i].ptgt, vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
      step();
      chk($sformatf("v%0d_branch", i), {31'b0, bif.branch}, {31'b0, vecs[i].eBranch});
      chk($sformatf("v%0d_taken", i), {31'b0, bif.wasTakenBranch}, {31'b0, vecs[i].eTaken});
      chk($sformatf("v%0d_mispredict", i), {31'b0, bif.mispredict}, {31'b0, vecs[i].eMiss});
      chk($sformatf("v%0d_count", i), {28'b0, bif.count}, {28'b0, vecs[i].eCount});
      chk($sformatf("v%0d_fetchReady", i), {31'b0, bif.fetchReady}, {31'b0, vecs[i].eFr});
      chk($sformatf("v%0d_resReady", i), {31'b0, bif.resReady}, {31'b0, vecs[i].eRr});
      if (vecs[i].eBranch) begin
        chk($sformatf("v%0d_oldPC", i), {24'b0, bif.oldPC}, {24'b0, vecs[i].eOld});
        chk($sformatf("v%0d_resolvedTarget", i), bif.resolvedTarget, vecs[i].eTgt);
      end
      if (vecs[i].eMiss)
        chk($sformatf("v%0d_redirectPC", i), bif.redirectPC, vecs[i].eRedir);
    end

    // fill to capacity, then stream push+resolve across the pointer wrap
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    begin
      int nextIdx;
      nextIdx = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        drive(1, 32'h1000 + 32'(nextIdx) * 4, nextIdx[0], 32'h2000 + 32'(nextIdx) * 16, 0, 0, 0);
        qPC.push_back(32'h1000 + 32'(nextIdx) * 4);
        qT.push_back(nextIdx[0]);
        qTgt.push_back(32'h2000 + 32'(nextIdx) * 16);
        nextIdx++;
        step();
      end
      chk("full_count", {28'b0, bif.count}, 32'd8);
      chk("full_fetchReady", {31'b0, bif.fetchReady}, 32'h0);
      for (int c = 0; c < 20; c++) begin
        logic        accept;
        logic [31:0] hPC;
        logic        hT;
        logic [31:0] hTgt;
        @(negedge clk);
        hPC  = qPC[0];
        hT   = qT[0];
        hTgt = qTgt[0];
        accept = (qPC.size() < 8);
        drive(1, 32'h1000 + 32'(nextIdx) * 4, nextIdx[0], 32'h2000 + 32'(nextIdx) * 16,
              1, hT, hT ? hTgt : 32'h0);
        void'(qPC.pop_front());
        void'(qT.pop_front());
        void'(qTgt.pop_front());
        if (accept) begin
          qPC.push_back(32'h1000 + 32'(nextIdx) * 4);
          qT.push_back(nextIdx[0]);
          qTgt.push_back(32'h2000 + 32'(nextIdx) * 16);
          nextIdx++;
        end
        step();
        chk($sformatf("wrap%0d_branch", c), {31'b0, bif.branch}, 32'h1);
        chk($sformatf("wrap%0d_oldPC", c), {24'b0, bif.oldPC}, {24'b0, hPC[7:0]});
        chk($sformatf("wrap%0d_taken", c), {31'b0, bif.wasTakenBranch}, {31'b0, hT});
        chk($sformatf("wrap%0d_mispredict", c), {31'b0, bif.mispredict}, 32'h0);
        chk($sformatf("wrap%0d_count", c), {28'b0, bif.count}, 32'(qPC.size()));
      end
    end

    // resolve down to 5 queued entries, then assert reset between edges
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, qT[0], qT[0] ? qTgt[0] : 32'h0);
      void'(qPC.pop_front());
      void'(qT.pop_front());
      void'(qTgt.pop_front());
      step();
    end
    chk("pre_rst_count", {28'b0, bif.count}, 32'd5);
    chk("pre_rst_branch", {31'b0, bif.branch}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_branch", {31'b0, bif.branch}, 32'h0);
    chk("async_taken", {31'b0, bif.wasTakenBranch}, 32'h0);
    chk("async_oldPC", {24'b0, bif.oldPC}, 32'h0);
    chk("async_resolvedTarget", bif.resolvedTarget, 32'h0);
    chk("async_count", {28'b0, bif.count}, 32'h0);
    chk("async_resReady", {31'b0, bif.resReady}, 32'h0);
    chk("async_fetchReady", {31'b0, bif.fetchReady}, 32'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_branch", {31'b0, bif.branch}, 32'h0);
    chk("post_rst_count", {28'b0, bif.count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
